// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the three buses around the issue controller.
//   in_*   : upstream instruction (valid/ready), driven by register read
//   alu_*  : operand/op toward the combinational ALU and its Result/Zero back
//   out_*  : captured result toward writeback/branch logic (valid/ready)
// Modports: slave = the issue controller, master = its surroundings.
interface alu_issue_if #(
   parameter int W     = 32,
   parameter int IMM_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_opcode;
   logic [5:0]       in_funct;
   logic [W-1:0]     in_rs_val;
   logic [W-1:0]     in_rt_val;
   logic [IMM_W-1:0] in_imm;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [3:0]       alu_op;
   logic [W-1:0]     alu_result;
   logic             alu_zero;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_result;
   logic             out_zero;
   logic             out_br_taken;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_result, alu_zero,
      output out_valid, out_result, out_zero, out_br_taken, out_illegal,
      input  out_ready
   );

   modport master (
      output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_result, alu_zero,
      input  out_valid, out_result, out_zero, out_br_taken, out_illegal,
      output out_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/decode stage in front of a combinational ALU.
// Accepts one decoded instruction, registers the ALU operands/op, captures the
// ALU Result/Zero one cycle later and hands it downstream, resolving BEQ/BNE.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (drops any in-flight instruction)
//   bus    alu_issue_if.slave: in_* handshake, alu_* operand bus, out_* handshake
// Three-state flow IDLE -> EXEC -> DONE, so at most one instruction every 3 cycles.
module alu_issue_ctrl #(
   parameter int         W      = 32,
   parameter int         IMM_W  = 16,
   parameter logic [3:0] NOP_OP = 4'b1111
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_issue_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t state, state_nx;
   logic   accept, capture, release_q;

   logic [3:0]   dec_op;
   logic [W-1:0] dec_a, dec_b;
   logic         dec_beq, dec_bne, dec_ill;
   logic         beq_q, bne_q, ill_q;

   logic [W-1:0] imm_sx, imm_zx;
   assign imm_sx = {{(W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
   assign imm_zx = {{(W-IMM_W){1'b0}}, bus.in_imm};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      release_q = 1'b0;
      case (state)
         IDLE: if (bus.in_valid) begin
            accept   = 1'b1;
            state_nx = EXEC;
         end
         EXEC: begin
            capture  = 1'b1;
            state_nx = DONE;
         end
         DONE: if (bus.out_ready) begin
            release_q = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.in_ready = (state == IDLE);

   // ---------------- decode ----------------
   // Illegal encodings keep the defaults: NOP_OP with zero operands.
   always_comb begin
      dec_op  = NOP_OP;
      dec_a   = '0;
      dec_b   = '0;
      dec_beq = 1'b0;
      dec_bne = 1'b0;
      dec_ill = 1'b0;
      case (bus.in_opcode)
         6'h00: begin
            case (bus.in_funct)
               6'h20: begin dec_op = 4'b0000; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; end
               6'h22: begin dec_op = 4'b0010; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; end
               6'h24: begin dec_op = 4'b0100; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; end
               6'h25: begin dec_op = 4'b0101; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; end
               6'h26: begin dec_op = 4'b0110; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; end
               6'h27: begin dec_op = 4'b0111; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; end
               // The ALU's compare op is "A > B", so rs < rt needs the operands swapped.
               6'h2A: begin dec_op = 4'b1010; dec_a = bus.in_rt_val; dec_b = bus.in_rs_val; end
               default: dec_ill = 1'b1;
            endcase
         end
         6'h08: begin dec_op = 4'b0000; dec_a = bus.in_rs_val; dec_b = imm_sx; end
         6'h0C: begin dec_op = 4'b0100; dec_a = bus.in_rs_val; dec_b = imm_zx; end
         6'h0D: begin dec_op = 4'b0101; dec_a = bus.in_rs_val; dec_b = imm_zx; end
         6'h04: begin dec_op = 4'b0010; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; dec_beq = 1'b1; end
         6'h05: begin dec_op = 4'b0010; dec_a = bus.in_rs_val; dec_b = bus.in_rt_val; dec_bne = 1'b1; end
         default: dec_ill = 1'b1;
      endcase
   end

   // ---------------- datapath ----------------
   // alu_* hold until the next accept; out_* hold until the next capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_a        <= '0;
         bus.alu_b        <= '0;
         bus.alu_op       <= '0;
         beq_q            <= 1'b0;
         bne_q            <= 1'b0;
         ill_q            <= 1'b0;
         bus.out_valid    <= 1'b0;
         bus.out_result   <= '0;
         bus.out_zero     <= 1'b0;
         bus.out_br_taken <= 1'b0;
         bus.out_illegal  <= 1'b0;
      end else begin
         if (accept) begin
            bus.alu_a  <= dec_a;
            bus.alu_b  <= dec_b;
            bus.alu_op <= dec_op;
            beq_q      <= dec_beq;
            bne_q      <= dec_bne;
            ill_q      <= dec_ill;
         end
         if (capture) begin
            bus.out_valid    <= 1'b1;
            bus.out_result   <= bus.alu_result;
            bus.out_zero     <= bus.alu_zero;
            bus.out_br_taken <= (beq_q & bus.alu_zero) | (bne_q & ~bus.alu_zero);
            bus.out_illegal  <= ill_q;
         end else if (release_q) begin
            bus.out_valid    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the alu_* bus, a vector table
// of directed instructions, hand-written backpressure/reset sequences and
// random instructions checked against an instruction-level reference model.
module tb_alu_issue_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_issue_if #(.W(32), .IMM_W(16)) bus();
   alu_issue_ctrl #(.W(32), .IMM_W(16), .NOP_OP(4'b1111)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));

   // Combinational ALU the controller drives
   always_comb begin
      bus.alu_result = 32'h0;
      case (bus.alu_op)
         4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
         4'b0010: bus.alu_result = bus.alu_a - bus.alu_b;
         4'b0100: bus.alu_result = bus.alu_a & bus.alu_b;
         4'b0101: bus.alu_result = bus.alu_a | bus.alu_b;
         4'b0110: bus.alu_result = bus.alu_a ^ bus.alu_b;
         4'b0111: bus.alu_result = ~(bus.alu_a | bus.alu_b);
         4'b1010: bus.alu_result = {31'h0, bus.alu_a > bus.alu_b};
         default: bus.alu_result = 32'h0;
      endcase
      bus.alu_zero = (bus.alu_result == 32'h0);
   end

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
   endtask

   typedef struct {
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [3:0]  eop;
      logic [31:0] eres;
      logic        ez;
      logic        ebr;
      logic        eill;
   } vec_t;

   typedef struct {
      logic [31:0] a, b, res;
      logic [3:0]  op;
      logic        z, br, ill;
      int          lat;
   } obs_t;

   // Instruction-level reference: what the instruction means, not how it is decoded.
   task automatic ref_model(input logic [5:0] opc, input logic [5:0] fn,
                            input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                            output logic [31:0] res, output logic br, output logic ill);
      res = 0; br = 0; ill = 0;
      case (opc)
         6'h00: case (fn)
            6'h20: res = rs + rt;
            6'h22: res = rs - rt;
            6'h24: res = rs & rt;
            6'h25: res = rs | rt;
            6'h26: res = rs ^ rt;
            6'h27: res = ~(rs | rt);
            6'h2A: res = (rs < rt) ? 32'd1 : 32'd0;
            default: ill = 1;
         endcase
         6'h08: res = rs + 32'(signed'(imm));
         6'h0C: res = rs & {16'h0, imm};
         6'h0D: res = rs | {16'h0, imm};
         6'h04: begin res = rs - rt; br = (rs == rt); end
         6'h05: begin res = rs - rt; br = (rs != rt); end
         default: ill = 1;
      endcase
   endtask

   // Issue from IDLE (called #1 after a posedge); returns operand bus and result.
   // lat counts edges after the accepting edge until out_valid is seen.
   task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input int hold,
                        output obs_t o);
      bus.in_opcode = opc; bus.in_funct = fn; bus.in_rs_val = rs;
      bus.in_rt_val = rt; bus.in_imm = imm; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      o.a = bus.alu_a; o.b = bus.alu_b; o.op = bus.alu_op;
      o.lat = 0;
      while (!bus.out_valid && o.lat < 20) begin
         @(posedge clk); #1;
         o.lat++;
      end
      o.res = bus.out_result; o.z = bus.out_zero; o.br = bus.out_br_taken; o.ill = bus.out_illegal;
      repeat (hold) begin @(posedge clk); #1; end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   vec_t vt[16];
   obs_t o;
   logic [31:0] snap_res;

   initial begin
      vt[0]  = '{6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 0, 0, 0};
      vt[1]  = '{6'h08, 6'h00, 32'h5, 32'h0, 16'hFFFF, 32'h5, 32'hFFFFFFFF, 4'b0000, 32'h4, 0, 0, 0};
      vt[2]  = '{6'h00, 6'h2A, 32'h3, 32'h9, 16'h0, 32'h9, 32'h3, 4'b1010, 32'h1, 0, 0, 0};
      vt[3]  = '{6'h00, 6'h2A, 32'h9, 32'h3, 16'h0, 32'h3, 32'h9, 4'b1010, 32'h0, 1, 0, 0};
      vt[4]  = '{6'h04, 6'h00, 32'hA5, 32'hA5, 16'h0, 32'hA5, 32'hA5, 4'b0010, 32'h0, 1, 1, 0};
      vt[5]  = '{6'h05, 6'h00, 32'hA5, 32'hA5, 16'h0, 32'hA5, 32'hA5, 4'b0010, 32'h0, 1, 0, 0};
      vt[6]  = '{6'h3F, 6'h20, 32'h1234, 32'h5678, 16'h9, 32'h0, 32'h0, 4'b1111, 32'h0, 1, 0, 1};
      vt[7]  = '{6'h00, 6'h22, 32'h0, 32'h1, 16'h0, 32'h0, 32'h1, 4'b0010, 32'hFFFFFFFF, 0, 0, 0};
      vt[8]  = '{6'h0C, 6'h00, 32'hFFFF0F0F, 32'h0, 16'hF0F0, 32'hFFFF0F0F, 32'h0000F0F0, 4'b0100, 32'h0, 1, 0, 0};
      vt[9]  = '{6'h0D, 6'h00, 32'h12340000, 32'h0, 16'h8001, 32'h12340000, 32'h00008001, 4'b0101, 32'h12348001, 0, 0, 0};
      vt[10] = '{6'h00, 6'h27, 32'h0, 32'h0, 16'h0, 32'h0, 32'h0, 4'b0111, 32'hFFFFFFFF, 0, 0, 0};
      vt[11] = '{6'h00, 6'h21, 32'h7, 32'h8, 16'h0, 32'h0, 32'h0, 4'b1111, 32'h0, 1, 0, 1};
      vt[12] = '{6'h05, 6'h00, 32'h1, 32'h2, 16'h0, 32'h1, 32'h2, 4'b0010, 32'hFFFFFFFF, 0, 1, 0};
      vt[13] = '{6'h00, 6'h26, 32'hF0, 32'hFF, 16'h0, 32'hF0, 32'hFF, 4'b0110, 32'h0F, 0, 0, 0};
      vt[14] = '{6'h00, 6'h24, 32'hF0, 32'h3C, 16'h0, 32'hF0, 32'h3C, 4'b0100, 32'h30, 0, 0, 0};
      vt[15] = '{6'h00, 6'h25, 32'hF0, 32'h3C, 16'h0, 32'hF0, 32'h3C, 4'b0101, 32'hFC, 0, 0, 0};

      bus.in_valid = 0; bus.in_opcode = 0; bus.in_funct = 0; bus.in_rs_val = 0;
      bus.in_rt_val = 0; bus.in_imm = 0; bus.out_ready = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_out_flags", {bus.out_result, bus.out_zero, bus.out_br_taken, bus.out_illegal}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 16; i++) begin
         issue(vt[i].opc, vt[i].fn, vt[i].rs, vt[i].rt, vt[i].imm, i % 3, o);
         chk($sformatf("v%0d_alu_a", i), o.a, vt[i].ea);
         chk($sformatf("v%0d_alu_b", i), o.b, vt[i].eb);
         chk($sformatf("v%0d_alu_op", i), o.op, vt[i].eop);
         chk($sformatf("v%0d_latency", i), o.lat, 1);
         chk($sformatf("v%0d_result", i), o.res, vt[i].eres);
         chk($sformatf("v%0d_zero", i), o.z, vt[i].ez);
         chk($sformatf("v%0d_br", i), o.br, vt[i].ebr);
         chk($sformatf("v%0d_ill", i), o.ill, vt[i].eill);
         chk($sformatf("v%0d_back_idle", i), {bus.in_ready, bus.out_valid}, 2'b10);
      end

      // Backpressure: outputs frozen, no accept while downstream stalls
      bus.in_opcode = 6'h00; bus.in_funct = 6'h20; bus.in_rs_val = 32'd10;
      bus.in_rt_val = 32'd20; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      snap_res = bus.out_result;
      chk("bp_result", snap_res, 32'd30);
      bus.in_valid = 1'b1;  // a second request must not be taken while stalled
      bus.in_funct = 6'h22;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d", c),
             {bus.out_valid, bus.in_ready, bus.out_result, bus.out_zero, bus.alu_op},
             {1'b1, 1'b0, 32'd30, 1'b0, 4'b0000});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);

      // Reset while in EXEC drops the instruction
      bus.in_opcode = 6'h00; bus.in_funct = 6'h20; bus.in_rs_val = 32'h11;
      bus.in_rt_val = 32'h22; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("exec_alu_a", bus.alu_a, 32'h11);
      rst_n = 1'b0;
      #1;
      chk("rst_exec_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
      chk("rst_exec_out", {bus.out_valid, bus.out_result, bus.out_zero, bus.out_br_taken, bus.out_illegal}, 0);
      chk("rst_exec_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_exec_dropped", bus.out_valid, 0);

      // Random instructions vs reference model
      for (int n = 0; n < 300; n++) begin
         logic [5:0]  opc, fn;
         logic [31:0] rs, rt, eres;
         logic [15:0] imm;
         logic        ebr, eill;
         case ($urandom_range(0, 6))
            0: opc = 6'h00; 1: opc = 6'h08; 2: opc = 6'h0C; 3: opc = 6'h0D;
            4: opc = 6'h04; 5: opc = 6'h05; default: opc = 6'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h26; 5: fn = 6'h27; 6: fn = 6'h2A; default: fn = 6'($urandom);
         endcase
         rs  = $urandom;
         rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
         imm = 16'($urandom);
         ref_model(opc, fn, rs, rt, imm, eres, ebr, eill);
         issue(opc, fn, rs, rt, imm, $urandom_range(0, 2), o);
         chk($sformatf("rnd%0d_res op=%0h fn=%0h", n, opc, fn), o.res, eres);
         chk($sformatf("rnd%0d_flags", n), {o.z, o.br, o.ill}, {eres == 32'h0, ebr, eill});
         chk($sformatf("rnd%0d_latency", n), o.lat, 1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
